// File: rtl/parallel_pio_pkg.sv
// Shared types and widths for the FPGA->HPS PIO transmit controller.
// The PIO word is {phase toggle, 31-bit payload}.
package parallel_pio_pkg;

  localparam int unsigned PIO_W     = 32;
  localparam int unsigned PAYLOAD_W = 31;
  localparam int unsigned TOG_BIT   = 31;

  typedef enum logic [0:0] {
    StIdle,
    StWaitAck
  } pio_state_e;

  function automatic logic [PIO_W-1:0] pio_word(input logic                 tog,
                                                input logic [PAYLOAD_W-1:0] payload);
    return {tog, payload};
  endfunction

endpackage

// File: rtl/pio_word_fifo.sv
// Show-ahead synchronous FIFO: rdata_o always shows the head word while not empty.
// The count is one bit wider than the pointers so full and empty are distinct.
module pio_word_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 31
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AddrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only pointer-qualified entries are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/parallel_pio_tx_ctrl.sv
// FPGA->HPS PIO word sequencer using a two-phase toggle handshake on bit 31.
// Define PIO_TIMEOUT_EN to add the ack-wait timeout (timeout_err, FIFO flush, phase resync).
module parallel_pio_tx_ctrl
  import parallel_pio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [PAYLOAD_W-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [PIO_W-1:0]              parallel_input_export,
  input  logic                          hps_valid_export,
  input  logic                          err_clr,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          proto_err,
  output logic                          timeout_err
);

  pio_state_e           state_q;
  logic                 phase_tog_q;
  logic [PIO_W-1:0]     export_q;
  logic                 proto_err_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 ack_s, ack_prev_q;

  logic                 fifo_full, fifo_empty, fifo_push;
  logic [PAYLOAD_W-1:0] fifo_rdata;
  logic                 load, ack_match, timeout_hit;

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q     <= '0;
      ack_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], hps_valid_export};
      ack_prev_q <= ack_s;
    end
  end

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  pio_word_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (PAYLOAD_W)
  ) u_fifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (fifo_push),
    .wdata_i (in_data),
    .pop_i   (load),
    .flush_i (timeout_hit),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_level)
  );

`ifdef PIO_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] wait_cnt_q;
  logic            timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    load        = (state_q == StIdle) && !fifo_empty;
    ack_match   = (state_q == StWaitAck) && (ack_s == phase_tog_q);
    timeout_hit = 1'b0;
`ifdef PIO_TIMEOUT_EN
    // An ack arriving on the final cycle still completes normally.
    timeout_hit = (state_q == StWaitAck) && !ack_match &&
                  (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= StIdle;
      phase_tog_q <= 1'b0;
      export_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            export_q    <= pio_word(~phase_tog_q, fifo_rdata);
            phase_tog_q <= ~phase_tog_q;
            state_q     <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (ack_match) begin
            state_q <= StIdle;
          end else if (timeout_hit) begin
            // Adopt the HPS's current level so the next word is a fresh phase.
            phase_tog_q <= ack_s;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (err_clr) begin
        proto_err_q <= 1'b0;
      end else if ((state_q == StIdle) && (ack_s != ack_prev_q)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

`ifdef PIO_TIMEOUT_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (load) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWaitAck) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end

      if (err_clr) begin
        timeout_err_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign parallel_input_export = export_q;
  assign proto_err             = proto_err_q;
  assign busy                  = (state_q == StWaitAck) || !fifo_empty;

endmodule

// File: tb/tb_parallel_pio_tx_ctrl.sv
// Self-checking bench for parallel_pio_tx_ctrl: directed handshake cases plus a
// randomized producer/HPS run checked against a queue model of the word stream.
module tb_parallel_pio_tx_ctrl;

  localparam int unsigned FifoDepth = 8;
  localparam int unsigned SyncStg   = 2;
  localparam int unsigned ToCycles  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [30:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pio;
  logic        hps;
  logic        err_clr;
  logic        busy;
  logic [3:0]  fifo_level;
  logic        proto_err;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  parallel_pio_tx_ctrl #(
    .FIFO_DEPTH     (FifoDepth),
    .SYNC_STAGES    (SyncStg),
    .TIMEOUT_CYCLES (ToCycles)
  ) dut (
    .clk_clk               (clk),
    .reset_reset_n         (rst_n),
    .in_data               (in_data),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .parallel_input_export (pio),
    .hps_valid_export      (hps),
    .err_clr               (err_clr),
    .busy                  (busy),
    .fifo_level            (fifo_level),
    .proto_err             (proto_err),
    .timeout_err           (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;
    hps      = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic push_one(input logic [30:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [30:0] words[$];
    logic [30:0] w;
    logic [31:0] last_exp;
    logic        exp_tog;
    int          n_acc;
    int          dly;

    // Reset values, sampled while reset is still asserted.
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0; hps = 1'b0;
    step(2);
    chk("rst_export", pio, 32'h0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_proto", proto_err, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    rst_n = 1'b1;
    step(1);

    // 1: one word, HPS silent -> export appears one cycle after accept and holds.
    push_one(31'h1234_5678);
    chk("t1_level_after_accept", fifo_level, 4'd1);
    chk("t1_export_not_yet", pio, 32'h0);
    step(1);
    chk("t1_export", pio, 32'h9234_5678);
    chk("t1_level_popped", fifo_level, 4'd0);
    step(5);
    chk("t1_export_hold", pio, 32'h9234_5678);
    chk("t1_busy_hold", busy, 1'b1);

    // 2: ack turnaround is sync stages plus one cycle back to idle.
    do_reset();
    push_one(31'h0000_00AA);
    step(1);
    chk("t2_export", pio, 32'h8000_00AA);
    hps = 1'b1;
    step(SyncStg);
    chk("t2_busy_before_ack_seen", busy, 1'b1);
    step(1);
    chk("t2_busy_after_ack", busy, 1'b0);
    chk("t2_export_after_ack", pio, 32'h8000_00AA);
    chk("t2_no_proto", proto_err, 1'b0);

    // 3: fill with HPS stalled, then drain one ack at a time.
    do_reset();
    words.delete();
    n_acc = 0;
    while (in_ready && n_acc < 2 * FifoDepth) begin
      w = 31'($urandom);
      in_data  = w;
      in_valid = 1'b1;
      words.push_back(w);
      n_acc++;
      step(1);
    end
    in_valid = 1'b0;
    // One word sits on the export, the rest fill the FIFO.
    chk("t3_accepted", n_acc, FifoDepth + 1);
    chk("t3_ready_full", in_ready, 1'b0);
    chk("t3_level_full", fifo_level, FifoDepth);
    exp_tog = 1'b1;
    foreach (words[i]) begin
      chk($sformatf("t3_word%0d", i), pio, {exp_tog, words[i]});
      hps = exp_tog;
      step(SyncStg + 2);
      exp_tog = ~exp_tog;
    end
    chk("t3_busy_drained", busy, 1'b0);
    chk("t3_level_drained", fifo_level, 4'd0);
    chk("t3_ready_drained", in_ready, 1'b1);
    chk("t3_no_proto", proto_err, 1'b0);

    // 4: ack toggle while idle flags proto_err; clear wins over a same-cycle set.
    do_reset();
    hps = 1'b1;
    step(SyncStg);
    chk("t4_proto_not_yet", proto_err, 1'b0);
    step(1);
    chk("t4_proto_set", proto_err, 1'b1);
    chk("t4_state_unchanged", busy, 1'b0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("t4_proto_cleared", proto_err, 1'b0);
    hps = 1'b0;
    step(SyncStg);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("t4_clr_wins", proto_err, 1'b0);
    step(2);
    chk("t4_stays_clear", proto_err, 1'b0);

`ifdef PIO_TIMEOUT_EN
    // 5: no ack -> timeout after ToCycles cycles in the wait, FIFO flushed.
    do_reset();
    push_one(31'h0000_0011);
    step(1);
    chk("t5_export", pio, 32'h8000_0011);
    push_one(31'h0000_0022);
    push_one(31'h0000_0033);
    step(ToCycles - 4);
    chk("t5_no_timeout_early", timeout_err, 1'b0);
    chk("t5_level_before", fifo_level, 4'd2);
    in_data  = 31'h0000_0044;
    in_valid = 1'b1;
    step(1);
    chk("t5_no_timeout_last", timeout_err, 1'b0);
    in_data = 31'h0000_0055;
    step(1);
    in_valid = 1'b0;
    chk("t5_timeout_set", timeout_err, 1'b1);
    chk("t5_flushed", fifo_level, 4'd0);
    chk("t5_idle", busy, 1'b0);
    chk("t5_payload_held", pio, 32'h8000_0011);
    push_one(31'h0000_0066);
    step(1);
    chk("t5_next_phase", pio, 32'h8000_0066);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("t5_timeout_cleared", timeout_err, 1'b0);
`else
    // 5: without the timeout option the wait is unbounded.
    do_reset();
    push_one(31'h0000_0011);
    step(3 * ToCycles);
    chk("t5_no_timeout", timeout_err, 1'b0);
    chk("t5_still_waiting", busy, 1'b1);
    chk("t5_export_held", pio, 32'h8000_0011);
`endif

    // 6: asynchronous reset mid-transfer with words queued.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_data  = 31'(i + 1);
      in_valid = 1'b1;
      step(1);
    end
    in_valid = 1'b0;
    chk("t6_queued", fifo_level, 4'd3);
    chk("t6_export", pio, 32'h8000_0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_export", pio, 32'h0);
    chk("t6_rst_level", fifo_level, 4'd0);
    chk("t6_rst_ready", in_ready, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    step(1);

    // Random producer and HPS: export stream must match accepted words in order.
    do_reset();
    words.delete();
    last_exp = '0;
    dly      = -1;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (pio !== last_exp) begin
        if (words.size() == 0) begin
          chk("rnd_unexpected_load", pio, last_exp);
        end else begin
          w = words.pop_front();
          chk("rnd_word", pio, {~last_exp[31], w});
        end
        last_exp = pio;
      end
      chk("rnd_level", fifo_level, words.size());
      chk("rnd_ready", in_ready, words.size() < FifoDepth);
      if (dly < 0 && hps !== last_exp[31]) dly = $urandom_range(0, 5);
      if (dly == 0) begin
        hps = last_exp[31];
        dly = -1;
      end else if (dly > 0) begin
        dly--;
      end
      in_valid = (cyc < 500) && ($urandom_range(0, 2) != 0);
      in_data  = 31'($urandom);
      if (in_valid && in_ready) words.push_back(in_data);
      step(1);
    end
    in_valid = 1'b0;
    chk("rnd_all_sent", words.size(), 0);
    chk("rnd_busy_end", busy, 1'b0);
    chk("rnd_no_proto", proto_err, 1'b0);
    chk("rnd_no_timeout", timeout_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
